// File: rtl/fft_frame_sequencer_pkg.sv
// Shared definitions for the FFT frame sequencer.
//   state_t          : sequencer FSM states
//   DEF_FRAME_LEN    : default samples per analysis frame
//   DEF_TIMEOUT      : default engine watchdog limit in cycles
//   DEF_IDX_W        : default engine bin-index width
//   SAMPLE_MSB/LSB   : slice of the 32-bit audio word forwarded to the engine
//   MAG_W            : engine bin-magnitude width
package fft_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    START    = 3'd2,
    WAIT_RES = 3'd3,
    REPORT   = 3'd4
  } state_t;

  localparam int DEF_FRAME_LEN = 1024;
  localparam int DEF_TIMEOUT   = 2000000;
  localparam int DEF_IDX_W     = 11;

  localparam int SAMPLE_MSB = 31;
  localparam int SAMPLE_LSB = 16;
  localparam int SAMPLE_W   = SAMPLE_MSB - SAMPLE_LSB + 1;

  localparam int MAG_W = 64;

endpackage

// File: rtl/peak_bin_tracker.sv
// Running-maximum tracker for FFT result bins.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   clear          : zero the running peak
//   en             : bins are only considered while en is high
//   bin_valid      : mag/index carry a result bin this cycle
//   mag, index     : bin magnitude and index
//   nxt_mag/nxt_idx: running peak including this cycle's bin (combinational),
//                    so a result latched in the same cycle as the last bin
//                    already reflects that bin.
// Bin 0 (DC) and mirror bins at or above FRAME_LEN/2 never qualify; a bin
// must be strictly larger than the current peak, so ties keep the earlier bin.
module peak_bin_tracker
  import fft_frame_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             bin_valid,
  input  logic [MAG_W-1:0] mag,
  input  logic [IDX_W-1:0] index,
  output logic [MAG_W-1:0] nxt_mag,
  output logic [IDX_W-1:0] nxt_idx
);

  localparam logic [IDX_W:0] HALF = (IDX_W+1)'(FRAME_LEN / 2);

  logic [MAG_W-1:0] run_mag;
  logic [IDX_W-1:0] run_idx;
  logic             qualify;

  always_comb begin
    qualify = en && bin_valid && (index != '0) && ({1'b0, index} < HALF) &&
              (mag > run_mag);
    nxt_mag = run_mag;
    nxt_idx = run_idx;
    if (qualify) begin
      nxt_mag = mag;
      nxt_idx = index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run_mag <= '0;
      run_idx <= '0;
    end else begin
      run_mag <= nxt_mag;
      run_idx <= nxt_idx;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Captures FRAME_LEN audio samples into an FFT engine, starts the engine,
// tracks the strongest result bin and reports it, with a watchdog on the
// engine.
// Ports:
//   CLOCK_50, reset            : clock, synchronous active-high reset
//   enable                     : allow a new frame (sampled in IDLE/REPORT)
//   audio_in_available         : audio controller holds a sample
//   sample_in                  : 32-bit audio word, upper half is used
//   read_audio_in              : pop strobe back to the audio controller
//   eng_sample/eng_sample_valid: sample stream to the engine
//   eng_start                  : one-cycle engine start pulse
//   eng_bin_valid/mag/index    : engine result bins
//   eng_done                   : engine finished the frame
//   peak_index/peak_mag        : strongest bin of the last frame
//   peak_valid                 : one-cycle result strobe
//   timeout_err                : one-cycle engine watchdog strobe
//   busy                       : FSM is not idle
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [31:0]         sample_in,
  output logic                read_audio_in,
  output logic [SAMPLE_W-1:0] eng_sample,
  output logic                eng_sample_valid,
  output logic                eng_start,
  input  logic                eng_bin_valid,
  input  logic [MAG_W-1:0]    eng_mag,
  input  logic [IDX_W-1:0]    eng_index,
  input  logic                eng_done,
  output logic [IDX_W-1:0]    peak_index,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                peak_valid,
  output logic                timeout_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WD_W-1:0]  wd;
  logic             pop;
  logic [MAG_W-1:0] nxt_mag;
  logic [IDX_W-1:0] nxt_idx;
  logic             unused_low_half;

  // Only the upper half of the audio word feeds the engine.
  assign unused_low_half = ^sample_in[SAMPLE_LSB-1:0];

  // Samples are drained in every non-idle state except START; only those
  // popped in CAPTURE reach the engine.
  assign pop = audio_in_available &&
               ((state == CAPTURE) || (state == WAIT_RES) || (state == REPORT));
  assign read_audio_in = pop;
  assign busy          = (state != IDLE);

  peak_bin_tracker #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_peak (
    .clk       (CLOCK_50),
    .reset     (reset),
    .clear     ((state == IDLE) || (state == REPORT)),
    .en        (state == WAIT_RES),
    .bin_valid (eng_bin_valid),
    .mag       (eng_mag),
    .index     (eng_index),
    .nxt_mag   (nxt_mag),
    .nxt_idx   (nxt_idx)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      wd               <= '0;
      eng_sample       <= '0;
      eng_sample_valid <= 1'b0;
      eng_start        <= 1'b0;
      peak_index       <= '0;
      peak_mag         <= '0;
      peak_valid       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      eng_sample_valid <= 1'b0;
      eng_start        <= 1'b0;
      peak_valid       <= 1'b0;
      timeout_err      <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (enable) state <= CAPTURE;
        end
        CAPTURE: begin
          if (pop) begin
            eng_sample_valid <= 1'b1;
            eng_sample       <= sample_in[SAMPLE_MSB:SAMPLE_LSB];
            count            <= count + 1'b1;
            if (count == LAST_CNT) begin
              state     <= START;
              eng_start <= 1'b1;
            end
          end
        end
        START: begin
          // START itself is the first counted cycle of the engine wait, so
          // the watchdog strobe lands TIMEOUT cycles after the start pulse.
          wd    <= WD_W'(1);
          state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (eng_done) begin
            // nxt_* already folds in a bin arriving alongside eng_done.
            state      <= REPORT;
            peak_valid <= 1'b1;
            peak_index <= nxt_idx;
            peak_mag   <= nxt_mag;
          end else if (wd >= WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        REPORT: begin
          count <= '0;
          state <= enable ? CAPTURE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;

  localparam int FRAME_LEN = 16;
  localparam int TIMEOUT   = 50;
  localparam int IDX_W     = 11;

  logic              CLOCK_50;
  logic              reset;
  logic              enable;
  logic              audio_in_available;
  logic [31:0]       sample_in;
  logic              read_audio_in;
  logic [15:0]       eng_sample;
  logic              eng_sample_valid;
  logic              eng_start;
  logic              eng_bin_valid;
  logic [63:0]       eng_mag;
  logic [IDX_W-1:0]  eng_index;
  logic              eng_done;
  logic [IDX_W-1:0]  peak_index;
  logic [63:0]       peak_mag;
  logic              peak_valid;
  logic              timeout_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  fft_frame_sequencer #(
    .FRAME_LEN (FRAME_LEN),
    .TIMEOUT   (TIMEOUT),
    .IDX_W     (IDX_W)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .reset              (reset),
    .enable             (enable),
    .audio_in_available (audio_in_available),
    .sample_in          (sample_in),
    .read_audio_in      (read_audio_in),
    .eng_sample         (eng_sample),
    .eng_sample_valid   (eng_sample_valid),
    .eng_start          (eng_start),
    .eng_bin_valid      (eng_bin_valid),
    .eng_mag            (eng_mag),
    .eng_index          (eng_index),
    .eng_done           (eng_done),
    .peak_index         (peak_index),
    .peak_mag           (peak_mag),
    .peak_valid         (peak_valid),
    .timeout_err        (timeout_err),
    .busy               (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: run did not finish, required finish before 200000");
    $fatal(1);
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Open a frame and feed it FRAME_LEN back-to-back samples; returns in the
  // START cycle.
  task automatic start_frame();
    enable = 1'b1;
    step();
    enable = 1'b0;
    audio_in_available = 1'b1;
    repeat (FRAME_LEN) step();
    audio_in_available = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++;
    if (eng_start !== 1'b0 || eng_sample_valid !== 1'b0 || peak_valid !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got start=%0b vld=%0b pv=%0b to=%0b expected all 0", eng_start, eng_sample_valid, peak_valid, timeout_err);
    end
    n_checks++;
    if (peak_mag !== 64'd0 || peak_index !== 11'd0 || eng_sample !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: got mag=%0d idx=%0d smp=%0h expected 0", peak_mag, peak_index, eng_sample);
    end
  endtask

  task automatic test_capture();
    int vld_seen;
    int start_seen;
    logic [15:0] exp_smp;
    vld_seen = 0;
    start_seen = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;  // dropping enable mid-capture must not abort the frame
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL capture_busy: got %0b expected 1", busy); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_smp = 16'(16'h0100 + i);
      audio_in_available = 1'b1;
      sample_in = {exp_smp, 16'hBEEF};
      #1;
      n_checks++;
      if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL capture_pop[%0d]: got %0b expected 1", i, read_audio_in); end
      step();
      if (eng_sample_valid === 1'b1) vld_seen++;
      if (eng_start === 1'b1) start_seen++;
      n_checks++;
      if (eng_sample_valid !== 1'b1 || eng_sample !== exp_smp) begin
        n_fail++; $display("FAIL capture_sample[%0d]: got vld=%0b smp=%0h expected vld=1 smp=%0h", i, eng_sample_valid, eng_sample, exp_smp);
      end
      n_checks++;
      if (eng_start !== (i == FRAME_LEN - 1)) begin
        n_fail++; $display("FAIL capture_start[%0d]: got %0b expected %0b", i, eng_start, (i == FRAME_LEN - 1));
      end
      if (i % 3 == 1) begin
        audio_in_available = 1'b0;
        #1;
        n_checks++;
        if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL capture_gap_pop[%0d]: got %0b expected 0", i, read_audio_in); end
        step();
        if (eng_sample_valid === 1'b1) vld_seen++;
        if (eng_start === 1'b1) start_seen++;
        n_checks++;
        if (eng_sample_valid !== 1'b0) begin n_fail++; $display("FAIL capture_gap_vld[%0d]: got %0b expected 0", i, eng_sample_valid); end
      end
    end
    audio_in_available = 1'b0;
    n_checks++;
    if (vld_seen != FRAME_LEN || start_seen != 1) begin
      n_fail++; $display("FAIL capture_counts: got vld=%0d start=%0d expected vld=%0d start=1", vld_seen, start_seen, FRAME_LEN);
    end
  endtask

  task automatic test_peak_search();
    logic [IDX_W-1:0] idx_tab [10];
    logic [63:0]      mag_tab [10];
    idx_tab = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd8, 11'd12};
    mag_tab = '{64'd900, 64'd5, 64'd40, 64'd40, 64'd7, 64'd3, 64'd2, 64'd1, 64'd1000, 64'd2000};
    step();  // START -> WAIT_RES
    n_checks++;
    if (eng_start !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle: got %0b expected 0", eng_start); end
    for (int i = 0; i < 10; i++) begin
      eng_bin_valid = 1'b1;
      eng_index = idx_tab[i];
      eng_mag = mag_tab[i];
      step();
    end
    eng_bin_valid = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    n_checks++;
    if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL peak_valid: got %0b expected 1", peak_valid); end
    n_checks++;
    if (peak_index !== 11'd2 || peak_mag !== 64'd40) begin
      n_fail++; $display("FAIL peak_result: got idx=%0d mag=%0d expected idx=2 mag=40", peak_index, peak_mag);
    end
    step();
    n_checks++;
    if (peak_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL peak_after: got pv=%0b busy=%0b expected pv=0 busy=0", peak_valid, busy);
    end
    n_checks++;
    if (peak_index !== 11'd2 || peak_mag !== 64'd40) begin
      n_fail++; $display("FAIL peak_hold: got idx=%0d mag=%0d expected idx=2 mag=40", peak_index, peak_mag);
    end
  endtask

  task automatic test_simultaneous_last_bin();
    start_frame();
    n_checks++;
    if (eng_start !== 1'b1) begin n_fail++; $display("FAIL simul_start: got %0b expected 1", eng_start); end
    // a bin arriving during START lies outside WAIT_RES and is ignored
    eng_bin_valid = 1'b1; eng_index = 11'd5; eng_mag = 64'd999;
    step();
    eng_index = 11'd1; eng_mag = 64'd50;
    step();
    eng_index = 11'd3; eng_mag = 64'd100; eng_done = 1'b1;
    step();
    eng_bin_valid = 1'b0; eng_done = 1'b0;
    n_checks++;
    if (peak_valid !== 1'b1 || peak_index !== 11'd3 || peak_mag !== 64'd100) begin
      n_fail++; $display("FAIL simul_result: got pv=%0b idx=%0d mag=%0d expected pv=1 idx=3 mag=100", peak_valid, peak_index, peak_mag);
    end
    step();
  endtask

  task automatic test_watchdog();
    start_frame();
    n_checks++;
    if (eng_start !== 1'b1) begin n_fail++; $display("FAIL wd_start: got %0b expected 1", eng_start); end
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      if (k < TIMEOUT) begin
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL wd_early[%0d]: got to=%0b busy=%0b expected to=0 busy=1", k, timeout_err, busy);
        end
      end else begin
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL wd_fire: got to=%0b busy=%0b expected to=1 busy=0", timeout_err, busy);
        end
        n_checks++;
        if (peak_valid !== 1'b0 || peak_index !== 11'd3 || peak_mag !== 64'd100) begin
          n_fail++; $display("FAIL wd_peak_hold: got pv=%0b idx=%0d mag=%0d expected pv=0 idx=3 mag=100", peak_valid, peak_index, peak_mag);
        end
      end
    end
    step();
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_one_cycle: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_reset_mid_capture();
    int early_start;
    early_start = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    audio_in_available = 1'b1;
    repeat (10) step();
    reset = 1'b1;  // audio still available: reset must win
    step();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || eng_sample_valid !== 1'b0 || eng_start !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got busy=%0b vld=%0b start=%0b expected 0", busy, eng_sample_valid, eng_start);
    end
    n_checks++;
    if (peak_index !== 11'd0 || peak_mag !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_peak: got idx=%0d mag=%0d expected 0", peak_index, peak_mag);
    end
    n_checks++;
    if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL rstmid_pop: got %0b expected 0", read_audio_in); end
    repeat (3) begin
      step();
      if (eng_start === 1'b1) early_start++;
    end
    audio_in_available = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    audio_in_available = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      step();
      if (i < FRAME_LEN - 1 && eng_start === 1'b1) early_start++;
    end
    audio_in_available = 1'b0;
    n_checks++;
    if (early_start != 0) begin n_fail++; $display("FAIL rstmid_early_start: got %0d expected 0", early_start); end
    n_checks++;
    if (eng_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_full_frame: got %0b expected 1", eng_start); end
  endtask

  task automatic test_drain_restart();
    step();  // START -> WAIT_RES
    audio_in_available = 1'b1;
    sample_in = 32'hCAFE_0000;
    #1;
    n_checks++;
    if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL drain_pop: got %0b expected 1", read_audio_in); end
    step();
    n_checks++;
    if (eng_sample_valid !== 1'b0) begin n_fail++; $display("FAIL drain_vld: got %0b expected 0", eng_sample_valid); end
    audio_in_available = 1'b0;
    #1;
    n_checks++;
    if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL drain_nopop: got %0b expected 1'b0", read_audio_in); end
    enable = 1'b1;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    n_checks++;
    if (peak_valid !== 1'b1 || peak_index !== 11'd0 || peak_mag !== 64'd0) begin
      n_fail++; $display("FAIL drain_empty_result: got pv=%0b idx=%0d mag=%0d expected pv=1 idx=0 mag=0", peak_valid, peak_index, peak_mag);
    end
    audio_in_available = 1'b1;
    #1;
    n_checks++;
    if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL report_pop: got %0b expected 1", read_audio_in); end
    step();
    enable = 1'b0;
    n_checks++;
    if (eng_sample_valid !== 1'b0 || peak_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_state: got vld=%0b pv=%0b busy=%0b expected vld=0 pv=0 busy=1", eng_sample_valid, peak_valid, busy);
    end
    step();
    audio_in_available = 1'b0;
    n_checks++;
    if (eng_sample_valid !== 1'b1) begin n_fail++; $display("FAIL restart_capture: got %0b expected 1", eng_sample_valid); end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    audio_in_available = 1'b0;
    sample_in = 32'd0;
    eng_bin_valid = 1'b0;
    eng_mag = 64'd0;
    eng_index = '0;
    eng_done = 1'b0;
    test_reset();
    test_capture();
    test_peak_search();
    test_simultaneous_last_bin();
    test_watchdog();
    test_reset_mid_capture();
    test_drain_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
